// File: rtl/sum_serial_ctrl.sv
// Byte-serial wide add/subtract sequencer driving a single 8-bit ripple adder
// slice, LSB first, with the carry chained through a register between bytes.

module Sum_com8b (
  input  logic [7:0] i_A,
  input  logic [7:0] i_B,
  input  logic       i_Carry,
  output logic [7:0] o_Suma,
  output logic       o_Carry
);
  logic [8:0] c;

  always_comb begin
    c      = '0;
    o_Suma = '0;
    c[0]   = i_Carry;
    for (int unsigned i = 0; i < 8; i++) begin
      o_Suma[i] = i_A[i] ^ i_B[i] ^ c[i];
      c[i+1]    = (i_A[i] & i_B[i]) | (c[i] & (i_A[i] ^ i_B[i]));
    end
    o_Carry = c[8];
  end
endmodule

module sum_serial_ctrl #(
  parameter int unsigned N_BYTES = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Start,
  input  logic                 i_Sub,
  input  logic [8*N_BYTES-1:0] i_A,
  input  logic [8*N_BYTES-1:0] i_B,
  input  logic                 i_Carry,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic [8*N_BYTES-1:0] o_Suma,
  output logic                 o_Carry,
  output logic                 o_Ovf
);
  localparam int unsigned W  = 8 * N_BYTES;
  localparam int unsigned CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_reg, b_reg, res_reg;
  logic            carry_reg;
  logic [7:0]      add_sum;
  logic            add_co;
  logic            last, accept;

  assign last   = (cnt == CW'(N_BYTES - 1));
  assign accept = i_Start && (state != RUN);

  Sum_com8b u_add (
    .i_A     (a_reg[cnt*8 +: 8]),
    .i_B     (b_reg[cnt*8 +: 8]),
    .i_Carry (carry_reg),
    .o_Suma  (add_sum),
    .o_Carry (add_co)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_Busy    = 1'b0;
    o_Done    = 1'b0;
    case (state)
      IDLE: if (i_Start) state_nxt = RUN;
      RUN: begin
        o_Busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        o_Done    = 1'b1;
        state_nxt = i_Start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      o_Suma    <= '0;
      o_Carry   <= 1'b0;
      o_Ovf     <= 1'b0;
    end else if (accept) begin
      a_reg     <= i_A;
      b_reg     <= i_Sub ? ~i_B : i_B;
      carry_reg <= i_Sub | i_Carry;
      cnt       <= '0;
    end else if (state == RUN) begin
      res_reg[cnt*8 +: 8] <= add_sum;
      carry_reg           <= add_co;
      cnt                 <= last ? '0 : cnt + 1'b1;
      // Top byte is merged straight from the adder so outputs land on DONE entry.
      if (last) begin
        o_Suma  <= {add_sum, res_reg[W-9:0]};
        o_Carry <= add_co;
        o_Ovf   <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[7] != a_reg[W-1]);
      end
    end
  end
endmodule

// File: tb/tb_sum_serial_ctrl.sv
// Directed bench for sum_serial_ctrl (N_BYTES=4) with hand-computed results.

module tb_sum_serial_ctrl;
  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, sub, cin;
  logic [W-1:0] a, b;
  logic         busy, done, co, ovf;
  logic [W-1:0] suma;

  int n_cmp = 0;
  int n_err = 0;

  sum_serial_ctrl #(.N_BYTES(NB)) dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Start (start),
    .i_Sub   (sub),
    .i_A     (a),
    .i_B     (b),
    .i_Carry (cin),
    .o_Busy  (busy),
    .o_Done  (done),
    .o_Suma  (suma),
    .o_Carry (co),
    .o_Ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge; it is accepted at the following rising edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts, input logic tc);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk);
  endtask

  // Called just after the accept edge. Returns the index of the edge (relative to
  // the accept edge) at which o_Done is sampled high, and the count of busy cycles.
  // poke: pulse a new start with other operands in the second RUN cycle.
  // chain: raise a new start (A=1,B=2) in the DONE cycle.
  task automatic wait_done(input bit poke, input bit chain, output int edge_idx, output int busy_n);
    edge_idx = -1;
    busy_n   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && c == 1) begin
        a = 32'hDEADBEEF; b = 32'h01010101; sub = 1'b1; start = 1'b1;
      end
      if (poke && c == 2) check("hold_mid_op", suma, 32'h7FFFFFFF);
      if (busy) busy_n++;
      if (done) begin
        edge_idx = c + 1;
        if (chain) begin
          a = 32'd1; b = 32'd2; sub = 1'b0; cin = 1'b0; start = 1'b1;
        end
        break;
      end
    end
    if (edge_idx < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    check({tag, "_suma"}, suma, es);
    check({tag, "_carry"}, co, ec);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int e, bn;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_suma", suma, 0);
    check("rst_carry", co, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;

    launch(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    wait_done(0, 0, e, bn);
    check("add_latency", e, NB + 1);
    check("add_busy_cycles", bn, NB);
    op_check("add", 32'h00000100, 0, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    launch(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    wait_done(0, 0, e, bn);
    op_check("chain", 32'h00000000, 1, 0);

    launch(32'd5, 32'd7, 1'b1, 1'b1);
    wait_done(0, 0, e, bn);
    op_check("sub_c1", 32'hFFFFFFFE, 0, 0);

    launch(32'd5, 32'd7, 1'b1, 1'b0);
    wait_done(0, 0, e, bn);
    op_check("sub_c0", 32'hFFFFFFFE, 0, 0);

    launch(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
    wait_done(0, 0, e, bn);
    op_check("ovf_add", 32'h80000000, 0, 1);

    launch(32'h80000000, 32'd1, 1'b1, 1'b0);
    wait_done(0, 0, e, bn);
    op_check("ovf_sub", 32'h7FFFFFFF, 1, 1);

    // Start during RUN is ignored; start in DONE is accepted back-to-back.
    launch(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    wait_done(1, 1, e, bn);
    check("poke_latency", e, NB + 1);
    op_check("poke", 32'h23456789, 0, 0);
    @(posedge clk);
    wait_done(0, 0, e, bn);
    check("b2b_latency", e, NB + 1);
    op_check("b2b", 32'h00000003, 0, 0);

    // Asynchronous reset in the second RUN cycle.
    launch(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_suma", suma, 0);
    check("arst_carry", co, 0);
    check("arst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("arst_no_done", seen, 0);
    end

    launch(32'd2, 32'd3, 1'b0, 1'b0);
    wait_done(0, 0, e, bn);
    check("post_rst_latency", e, NB + 1);
    op_check("post_rst", 32'd5, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
